// File: rtl/cpu_bus_ram.sv
// cpu_bus_ram: RAM responder for a 6502-style CPU bus (addr/data/rw).
//
// After reset a byte-serial loader fills the memory while the CPU is held in
// reset. Once the last byte arrives (or the pointer wraps past the top), the
// block releases the CPU and serves bus reads and writes. The bus is sampled
// only on the one-cycle qstb strobe. Read data appears the clk4 cycle after the
// strobe.
//
// Optional feature, macro CPU_BUS_RAM_WP_EN: CPU writes to offsets below
// WP_TOP are rejected and pulse wp_err. Loader writes are never protected.
// With the macro undefined, every RUN write is performed and wp_err stays 0.
//
// Ports:
//   clk4      fast clock; all state changes on its rising edge
//   n_reset   asynchronous active-low reset
//   qstb      bus sample strobe, one clk4 cycle per CPU cycle
//   addr      CPU address
//   rw        1 = CPU read, 0 = CPU write
//   data_in   bus write data
//   data_out  read data toward the bus
//   data_oe   drive enable for data_out
//   cpu_hold  1 while loading; keeps the CPU in reset
//   ld_valid  loader byte valid
//   ld_data   loader byte
//   ld_last   marks the final loader byte
//   ld_ready  loader may transfer
//   ld_start  pulse in RUN: restart loading from offset 0
//   wp_err    one-cycle pulse on a rejected CPU write

module cpu_bus_ram #(
    parameter int unsigned AW     = 7,
    parameter logic [15:0] BASE   = 16'h0000,
    parameter int unsigned WP_TOP = 16
) (
    input  logic        clk4,
    input  logic        n_reset,
    input  logic        qstb,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        cpu_hold,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        ld_start,
    output logic        wp_err
);

    localparam int unsigned Depth = 2 ** AW;

`ifdef CPU_BUS_RAM_WP_EN
    localparam bit WpEn = 1'b1;
`else
    localparam bit WpEn = 1'b0;
`endif

    typedef enum logic [0:0] {
        StLoad,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [7:0]      dout_q, dout_d;
    logic            oe_q, oe_d;
    logic            wp_err_q, wp_err_d;

    logic [7:0]      mem_q [Depth];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;

    logic            sel;
    logic [AW-1:0]   offset;
    logic            wp_block;

    assign sel    = (addr[15:AW] == BASE[15:AW]);
    assign offset = addr[AW-1:0];

    // Constant-folds to 0 when the protection feature is not compiled in.
    assign wp_block = WpEn && (32'(offset) < WP_TOP);

    // Next-state, memory write port and read-data capture.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        wp_err_d  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = ld_data;

        unique case (state_q)
            StLoad: begin
                // ld_ready is 1 throughout LOAD, so ld_valid alone is a transfer.
                // The CPU bus is ignored entirely here.
                if (ld_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + AW'(1);
                    if (ld_last || (ptr_q == {AW{1'b1}})) begin
                        state_d = StRun;
                    end
                end
            end

            StRun: begin
                if (ld_start) begin
                    // A reload request takes priority over a strobe in the same cycle.
                    state_d = StLoad;
                    ptr_d   = '0;
                    oe_d    = 1'b0;
                end else if (qstb) begin
                    if (!sel) begin
                        oe_d = 1'b0;
                    end else if (rw) begin
                        dout_d = mem_q[offset];
                        oe_d   = 1'b1;
                    end else begin
                        oe_d = 1'b0;
                        if (wp_block) begin
                            wp_err_d = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = offset;
                            mem_wdata = data_in;
                        end
                    end
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= StLoad;
            ptr_q    <= '0;
            dout_q   <= 8'h00;
            oe_q     <= 1'b0;
            wp_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            wp_err_q <= wp_err_d;
        end
    end

    // Storage is deliberately not reset: a partial load keeps its bytes.
    always_ff @(posedge clk4) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ld_ready = (state_q == StLoad);
    assign cpu_hold = (state_q == StLoad);
    assign data_out = dout_q;
    // Gated by live rw so the drive releases the moment the CPU turns the bus around.
    assign data_oe  = oe_q & rw & (state_q == StRun);
    assign wp_err   = wp_err_q;

endmodule

// File: tb/tb_cpu_bus_ram.sv
module tb_cpu_bus_ram;

    localparam int Depth = 128;
    localparam int WpTop = 16;

`ifdef CPU_BUS_RAM_WP_EN
    localparam bit WpEn = 1'b1;
`else
    localparam bit WpEn = 1'b0;
`endif

    logic        clk4 = 1'b0;
    logic        n_reset = 1'b1;
    logic        qstb, rw, ld_valid, ld_last, ld_start;
    logic [15:0] addr;
    logic [7:0]  data_in, ld_data;
    logic [7:0]  data_out;
    logic        data_oe, cpu_hold, ld_ready, wp_err;

    cpu_bus_ram dut (
        .clk4     (clk4),
        .n_reset  (n_reset),
        .qstb     (qstb),
        .addr     (addr),
        .rw       (rw),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .cpu_hold (cpu_hold),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_start (ld_start),
        .wp_err   (wp_err)
    );

    always #5 clk4 = ~clk4;

    typedef struct {
        logic       oe;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  ref_mem [Depth];
    int          ref_ptr;
    logic [7:0]  last_dout;
    logic [7:0]  bq[$];
    bit          rd_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk4);
        #1;
    endtask

    // One loader byte, preceded by random stalls during which bus writes are
    // strobed; the model ignores them because the CPU is held.
    task automatic push_byte(input logic [7:0] d, input bit last);
        int stalls;
        stalls = $urandom_range(0, 2);
        for (int i = 0; i < stalls; i++) begin
            ld_valid = 1'b0;
            qstb     = 1'b1;
            rw       = 1'b0;
            addr     = {9'b0, 7'($urandom)};
            data_in  = 8'($urandom);
            tick();
        end
        qstb     = 1'b0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        check("hold_before_xfer", cpu_hold, 1);
        check("ready_before_xfer", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ref_mem[ref_ptr] = d;
        ref_ptr = (ref_ptr + 1) % Depth;
    endtask

    task automatic load_bytes(input logic [7:0] bytes[$], input bit last_on_end);
        for (int i = 0; i < bytes.size(); i++) begin
            push_byte(bytes[i], last_on_end && (i == bytes.size() - 1));
        end
        check("hold_after_load", cpu_hold, 0);
        check("ready_after_load", ld_ready, 0);
    endtask

    // One CPU bus cycle: strobe, hold, then turn the bus around.
    task automatic bus(input logic [15:0] a, input bit r, input logic [7:0] wd);
        bit   s;
        int   off;
        bit   prot;
        exp_t e;
        s    = (a[15:7] == 9'd0);
        off  = int'(a[6:0]);
        prot = WpEn && (off < WpTop);
        qstb    = 1'b1;
        addr    = a;
        rw      = r;
        data_in = wd;
        if (r) begin
            e.oe   = s;
            e.data = s ? ref_mem[off] : last_dout;
            if (s) last_dout = ref_mem[off];
            exp_q.push_back(e);
        end else if (s && !prot) begin
            ref_mem[off] = wd;
        end
        tick();
        qstb = 1'b0;
        if (!r) begin
            @(negedge clk4);
            check("wp_err", wp_err, s && prot);
            tick();
        end else begin
            tick();
        end
        rw   = 1'b0;
        addr = 16'hFFFF;
        if (r) begin
            #1;
            check("oe_drop_on_rw", data_oe, 0);
        end
        tick();
    endtask

    // Monitor: the cycle after every read strobe, pop and compare.
    initial begin
        rd_pend = 1'b0;
        forever begin
            @(negedge clk4);
            if (rd_pend) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rd_oe", data_oe, e.oe);
                    check("rd_data", data_out, e.data);
                end
            end
            rd_pend = qstb && rw && n_reset && !ld_start;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        qstb = 0; rw = 0; ld_valid = 0; ld_last = 0; ld_start = 0;
        addr = 16'hFFFF; data_in = 0; ld_data = 0;
        ref_ptr = 0;
        last_dout = 8'h00;
        n_reset = 1'b0;
        #2;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_data_oe", data_oe, 0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_wp_err", wp_err, 0);
        tick();
        tick();
        n_reset = 1'b1;
        tick();

        // Directed load and basic accesses.
        bq = {8'hA0, 8'h04, 8'h99, 8'h34};
        load_bytes(bq, 1'b1);
        bus(16'h0001, 1'b1, 8'h00);
        bus(16'h0012, 1'b0, 8'h55);
        bus(16'h0012, 1'b1, 8'h00);
        bus(16'h8000, 1'b1, 8'h00);
        bus(16'h0003, 1'b0, 8'hAA);
        bus(16'h0003, 1'b1, 8'h00);
        bus(16'h0010, 1'b0, 8'h5A);
        bus(16'h0010, 1'b1, 8'h00);

        // Full-depth load with no ld_last: pointer wraps and RUN follows.
        check("run_before_reload", cpu_hold, 0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ref_ptr = 0;
        bq.delete();
        for (int i = 0; i < Depth; i++) bq.push_back(8'($urandom));
        load_bytes(bq, 1'b0);
        check("ptr_wrapped", ref_ptr, 0);
        for (int i = 0; i < Depth; i++) bus(16'(i), 1'b1, 8'h00);

        // Random traffic, including unselected addresses.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 4) == 0) ? (16'h0080 | 16'($urandom))
                                            : {9'b0, 7'($urandom)};
            bus(a, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Reset in the middle of a load.
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ref_ptr = 0;
        push_byte(8'hC1, 1'b0);
        push_byte(8'hC2, 1'b0);
        n_reset = 1'b0;
        #1;
        check("midrst_cpu_hold", cpu_hold, 1);
        check("midrst_ld_ready", ld_ready, 1);
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_data_oe", data_oe, 0);
        last_dout = 8'h00;
        ref_ptr = 0;
        tick();
        n_reset = 1'b1;
        tick();
        bq = {8'hD0, 8'hD1, 8'hD2, 8'hD3};
        load_bytes(bq, 1'b1);
        for (int i = 0; i < 6; i++) bus(16'(i), 1'b1, 8'h00);

        // ld_start wins over a coinciding write strobe.
        ld_start = 1'b1;
        qstb     = 1'b1;
        rw       = 1'b0;
        addr     = 16'h0020;
        data_in  = 8'h77;
        tick();
        ld_start = 1'b0;
        qstb     = 1'b0;
        addr     = 16'hFFFF;
        check("ldstart_cpu_hold", cpu_hold, 1);
        check("ldstart_ld_ready", ld_ready, 1);
        ref_ptr = 0;
        bq = {8'h11, 8'h22, 8'h33};
        load_bytes(bq, 1'b1);
        for (int i = 0; i < 3; i++) bus(16'(i), 1'b1, 8'h00);
        bus(16'h0020, 1'b1, 8'h00);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ram.md
Name: cpu_bus_ram

Overview:
Synthesizable RAM responder for the 6502-style CPU bus (addr/data/rw), clocked from the fast clock clk4 and sampling the bus on a one-cycle phase strobe.
Holds a byte-serial loader that fills memory after reset while holding the CPU in reset, then serves CPU reads and writes.
Sits between the cpu core and the board-level bus tristate; top level drives the shared data wire from data_out/data_oe.

Parameters:
AW, 7, address bits decoded inside the block; memory depth 2**AW bytes
BASE, 16'h0000, base address; must be aligned to 2**AW; block selected when addr[15:AW] == BASE[15:AW]
WP_TOP, 16, number of low bytes (offset 0..WP_TOP-1) write-protected when the optional feature is compiled in

Ports:
clk4  input  1  fast clock; all state changes on posedge
n_reset  input  1  asynchronous, active-low reset
qstb  input  1  one-clk4-cycle strobe marking the bus sample point (one per CPU cycle)
addr  input  16  CPU address
rw  input  1  1 = CPU read, 0 = CPU write
data_in  input  8  bus data seen during CPU write
data_out  output  8  read data toward the bus
data_oe  output  1  drive enable for data_out
cpu_hold  output  1  1 = keep CPU in reset (loader active)
ld_valid  input  1  loader byte valid
ld_data  input  8  loader byte
ld_last  input  1  qualifies final loader byte
ld_ready  output  1  loader may transfer
ld_start  input  1  pulse in RUN: restart loading from offset 0
wp_err  output  1  one-cycle pulse on a rejected write (feature only; else tied 0)

Behaviour:
- Reset (async, n_reset=0): state LOAD, ptr=0, cpu_hold=1, ld_ready=1, oe_q=0, data_out=8'h00, wp_err=0. Memory contents not reset.
- States: LOAD, RUN.
- LOAD:
  - ld_ready=1, cpu_hold=1, data_oe=0.
  - All bus activity ignored: no memory access, data_out held.
  - Transfer = ld_valid & ld_ready: mem[ptr] <= ld_data, ptr <= ptr+1 (AW-bit wrap).
  - Transfer with ld_last=1, or transfer at ptr == 2**AW-1: next state RUN.
  - ld_valid=0 stalls; ptr unchanged.
- RUN:
  - ld_ready=0, cpu_hold=0 starting the first clk4 cycle after the final transfer.
  - ld_start=1: next state LOAD, ptr=0, cpu_hold=1 next cycle. Any qstb in that same cycle is ignored (load wins).
  - sel = addr[15:AW] == BASE[15:AW]; offset = addr[AW-1:0]. Bus is sampled only on qstb=1.
  - Read (qstb & rw & sel): data_out <= mem[offset]; oe_q <= 1. data_out is valid the clk4 cycle after qstb (latency 1).
  - Write (qstb & ~rw & sel): mem[offset] <= data_in; oe_q <= 0.
  - qstb & ~sel: oe_q <= 0; no write; data_out held.
  - data_oe = oe_q & rw & (state==RUN). It drops combinationally as soon as rw falls, so the bus never sees contention.
  - Read and write to the same offset on consecutive strobes: the read returns the newly written byte.
  - ld_valid/ld_data/ld_last are ignored in RUN.
- Reset mid-load or mid-run: returns immediately to reset values. Partially loaded memory keeps its bytes.

Optional Feature:
Macro CPU_BUS_RAM_WP_EN.
- Defined: in RUN, a write with sel and offset < WP_TOP leaves memory unchanged and pulses wp_err for one clk4 cycle, the cycle after qstb. Loader writes are never protected.
- Undefined: all RUN writes are performed; wp_err is constant 0.

Test Plan:
- Reset, then load A0,04,99,34 with ld_last on the 4th byte -> cpu_hold=1 through the 4th transfer and 0 the next cycle; ld_ready falls together with it.
- RUN, qstb with addr=16'h0001, rw=1 -> next cycle data_out=8'h04, data_oe=1; rw->0 -> data_oe=0 in the same cycle.
- Write 8'h55 to 16'h0012, then read 16'h0012 on the next strobe -> data_out=8'h55. Read 16'h8000 (unselected) -> data_oe=0, data_out unchanged.
- Loader back-pressure and wrap: toggle ld_valid over 128 bytes with no ld_last -> ptr wraps to 0 and the block enters RUN after byte 128; all bytes read back correctly.
- Assert n_reset mid-load (after 2 bytes), release, then reload -> cpu_hold=1 on reset and the load restarts at offset 0. In RUN, ld_start pulse coinciding with a qstb write -> write suppressed, state LOAD.
- CPU_BUS_RAM_WP_EN defined: write 8'hAA to 16'h0003 in RUN -> wp_err pulse, readback equals the loaded value. Write to 16'h0010 -> succeeds, no pulse.
